// File: rtl/fanout_responder.sv
// Fan-out endpoint for the req/ack token protocol: fetches tokens from one upstream
// responder and serves each token once to every downstream requester, independently.
module fanout_responder #(
  parameter int data_width  = 32,
  parameter int output_size = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   up_req,
  input  logic                   up_ack,
  input  logic [data_width-1:0]  up_din,
  input  logic [output_size-1:0] dn_req,
  output logic [output_size-1:0] dn_ack,
  output logic [data_width-1:0]  dn_dout,
  output logic [31:0]            count
);

  logic                   cur_valid;
  logic [data_width-1:0]  cur_data;
  logic                   nxt_valid;
  logic [data_width-1:0]  nxt_data;
  logic [output_size-1:0] served;
  logic [output_size-1:0] grant;
  logic                   retire;
  logic                   cur_open;
  logic                   nxt_open;

  // Masking with dn_ack keeps any port from being acked in two consecutive cycles.
  for (genvar gi = 0; gi < output_size; gi++) begin : g_grant
    assign grant[gi] = cur_valid & dn_req[gi] & ~served[gi] & ~dn_ack[gi];
  end

  assign retire   = cur_valid & (&(served | grant));
  // Slot availability as seen after this edge's retire has shifted nxt into cur.
  assign cur_open = ~cur_valid | (retire & ~nxt_valid);
  assign nxt_open = ~nxt_valid | retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      up_req    <= 1'b0;
      dn_ack    <= '0;
      dn_dout   <= '0;
      count     <= '0;
      served    <= '0;
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
    end else begin
      dn_ack <= grant;
      if (|grant) begin
        dn_dout <= cur_data;
      end

      if (up_ack) begin
        up_req <= 1'b0;
      end else if (!nxt_valid && !up_req) begin
        up_req <= 1'b1;
      end

      if (retire) begin
        served    <= '0;
        count     <= count + 32'd1;
        cur_valid <= nxt_valid;
        cur_data  <= nxt_data;
        nxt_valid <= 1'b0;
      end else begin
        served <= served | grant;
      end

      // Captures override the retire shift above; an ack with both slots busy is dropped.
      if (up_ack) begin
        if (cur_open) begin
          cur_data  <= up_din;
          cur_valid <= 1'b1;
        end else if (nxt_open) begin
          nxt_data  <= up_din;
          nxt_valid <= 1'b1;
        end
      end
    end
  end

endmodule
